// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and constants for the two-requester RAM arbiter.
// Contents : NUM_REQ  - number of requesters (2)
//            req_id_t - requester id (1 bit)
//            RD / WR  - decoding of the per-requester WE input
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_id_t;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-way round-robin picker owning its own priority flop.
//            A lone requester wins at once; on contention the priority holder
//            wins. After any grant the priority passes to the other requester.
// Ports    : clk_i   - clock, rising edge
//            rst_ni  - asynchronous active-low reset (also masks grants)
//            req_i   - request vector [1:0]
//            gnt_o   - one-hot grant vector (combinational)
//            win_o   - id of the granted requester (meaningful when |gnt_o)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output req_id_t              win_o
);

    req_id_t              pri_q;
    req_id_t              pri_d;
    logic [NUM_REQ-1:0]   req_v;

    always_comb begin
        // Grants are suppressed for the whole time reset is asserted.
        req_v = req_i & {NUM_REQ{rst_ni}};
        gnt_o = '0;
        win_o = pri_q;
        pri_d = pri_q;
        case (req_v)
            2'b01:   win_o = 1'b0;
            2'b10:   win_o = 1'b1;
            2'b11:   win_o = pri_q;
            default: win_o = pri_q;
        endcase
        if (|req_v) begin
            gnt_o[win_o] = 1'b1;
            pri_d        = ~win_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Arbitrates two requesters onto a simple dual-port RAM (one write
//            port, one registered read port). One write and one read may be
//            granted per cycle, each port with its own round-robin priority.
//            Read data (1-cycle latency) is steered back to the issuer.
// Ports    : CLK, RST_N                 - clock / async active-low reset
//            REQn, WEn, ADRn, WDATn     - requester n command (held until GNTn)
//            GNTn                       - combinational command accept
//            RVALIDn, RDATn             - read return (RDATn = 0 when !RVALIDn)
//            RAM_WEN/WADR/WDAT/RADR     - RAM command bus
//            RAM_RDAT                   - RAM registered read data
// Config   : RAM_ARB_WR_BYPASS_EN - when defined, a same-cycle same-address
//            granted write/read returns the newly written data.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int data_width = 8,
    parameter int adr_width  = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [adr_width-1:0]  ADR0,
    input  logic [adr_width-1:0]  ADR1,
    input  logic [data_width-1:0] WDAT0,
    input  logic [data_width-1:0] WDAT1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  RVALID0,
    output logic                  RVALID1,
    output logic [data_width-1:0] RDAT0,
    output logic [data_width-1:0] RDAT1,
    output logic                  RAM_WEN,
    output logic [adr_width-1:0]  RAM_WADR,
    output logic [data_width-1:0] RAM_WDAT,
    output logic [adr_width-1:0]  RAM_RADR,
    input  logic [data_width-1:0] RAM_RDAT
);

    logic [NUM_REQ-1:0]    wreq, rreq, wgnt, rgnt;
    req_id_t               wwin, rwin;
    logic                  rgrant;
    logic [adr_width-1:0]  wadr_q, wadr_d, radr_q, radr_d;
    logic [data_width-1:0] wdat_q, wdat_d;
    logic                  rpend_q, rpend_d;
    req_id_t               rsel_q, rsel_d;
    logic [data_width-1:0] rdata;

    assign wreq = {REQ1 & (WE1 == WR), REQ0 & (WE0 == WR)};
    assign rreq = {REQ1 & (WE1 == RD), REQ0 & (WE0 == RD)};

    rr_pick2 u_wr_pick (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .req_i  (wreq),
        .gnt_o  (wgnt),
        .win_o  (wwin)
    );

    rr_pick2 u_rd_pick (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .req_i  (rreq),
        .gnt_o  (rgnt),
        .win_o  (rwin)
    );

    // A requester is either a write or a read contender, never both.
    assign GNT0    = wgnt[0] | rgnt[0];
    assign GNT1    = wgnt[1] | rgnt[1];
    assign RAM_WEN = |wgnt;
    assign rgrant  = |rgnt;

    // Bus fields follow the winner; when idle they replay the last value so
    // the RAM never sees X.
    always_comb begin
        wadr_d = wadr_q;
        wdat_d = wdat_q;
        radr_d = radr_q;
        if (RAM_WEN) begin
            wadr_d = wwin ? ADR1  : ADR0;
            wdat_d = wwin ? WDAT1 : WDAT0;
        end
        if (rgrant) begin
            radr_d = rwin ? ADR1 : ADR0;
        end
    end

    assign RAM_WADR = wadr_d;
    assign RAM_WDAT = wdat_d;
    assign RAM_RADR = radr_d;

    assign rpend_d = rgrant;
    assign rsel_d  = rgrant ? rwin : rsel_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wadr_q  <= '0;
            wdat_q  <= '0;
            radr_q  <= '0;
            rpend_q <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            wadr_q  <= wadr_d;
            wdat_q  <= wdat_d;
            radr_q  <= radr_d;
            rpend_q <= rpend_d;
            rsel_q  <= rsel_d;
        end
    end

`ifdef RAM_ARB_WR_BYPASS_EN
    logic                  byp_q, byp_d;
    logic [data_width-1:0] bypdat_q;

    // The RAM returns old contents on a same-address collision, so capture
    // the write data and substitute it on the following cycle.
    assign byp_d = RAM_WEN & rgrant & (wadr_d == radr_d);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byp_q    <= 1'b0;
            bypdat_q <= '0;
        end else begin
            byp_q    <= byp_d;
            bypdat_q <= wdat_d;
        end
    end

    assign rdata = byp_q ? bypdat_q : RAM_RDAT;
`else
    assign rdata = RAM_RDAT;
`endif

    assign RVALID0 = rpend_q & (rsel_q == 1'b0);
    assign RVALID1 = rpend_q & (rsel_q == 1'b1);
    assign RDAT0   = RVALID0 ? rdata : '0;
    assign RDAT1   = RVALID1 ? rdata : '0;

endmodule : ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter in front of the simple dual-port `ram` (one write port, one registered read port). Each cycle it grants at most one write and one read, using independent round-robin priority per port. It issues the chosen commands to the RAM and routes the 1-cycle-latency read data back to the requester that issued the read. It sits between the CPU/loader-side masters and the shared RAM instance.

## Interface
- `data_width`, 8, RAM word width
- `adr_width`, 8, RAM address width
- `CLK` in 1: single clock, rising edge
- `RST_N` in 1: asynchronous, active-low reset
- `REQ0`/`REQ1` in 1: command request; held with its fields until granted
- `WE0`/`WE1` in 1: 1 = write, 0 = read
- `ADR0`/`ADR1` in adr_width: command address
- `WDAT0`/`WDAT1` in data_width: write data
- `GNT0`/`GNT1` out 1: combinational; command accepted this cycle when REQn & GNTn
- `RVALID0`/`RVALID1` out 1: read data valid, registered
- `RDAT0`/`RDAT1` out data_width: read data; 0 when RVALIDn = 0
- `RAM_WEN` out 1: to RAM `WEN`
- `RAM_WADR` out adr_width: to RAM `WADR`
- `RAM_WDAT` out data_width: to RAM `WDAT`
- `RAM_RADR` out adr_width: to RAM `RADR`
- `RAM_RDAT` in data_width: from RAM `RDAT`

## Operation
- Write port contenders: requesters with REQ=1, WE=1. Read port contenders: REQ=1, WE=0.
- Single contender on a port: granted immediately.
- Two contenders on a port: the holder of that port's priority bit (`wpri`/`rpri`) wins.
- Priority update: after any grant on a port to requester k, that port's priority moves to 1-k. A port with no grant keeps its priority.
- One read and one write in the same cycle, from different requesters: both granted.
- RAM drive:
  - `RAM_WEN` = write granted.
  - `RAM_WADR`/`RAM_WDAT` come from the write winner; they hold the last value when idle (no X on the bus).
  - `RAM_RADR` comes from the read winner.
- Read tracking: register `rsel` (winner id) and `rpend` (a read was granted). RVALIDk = rpend & (rsel == k). RDATk = RAM_RDAT when RVALIDk, else 0.
- Reset state:
  - All GNT outputs forced 0 while RST_N = 0.
  - RVALID0/1 = 0.
  - `wpri` = `rpri` = 0 (requester 0 first).
  - `rpend` = 0.
  - `RAM_WEN` = 0.
  - `RAM_WADR`/`RAM_WDAT`/`RAM_RADR` = 0.
- Reset asserted mid-read: the pending RVALID is dropped and not replayed.
- Same-address write and read granted in one cycle without bypass: the read returns the old RAM contents.

## Timing
- Grant: same cycle as request (combinational from REQ/WE and priority registers). No REQ→GNT loop through RAM.
- Write lands in RAM at the rising edge that ends the grant cycle.
- Read: granted in cycle N, RVALID/RDAT in cycle N+1. Fully pipelined: back-to-back reads give one RVALID per cycle.
- Worst-case wait for a contended requester is 1 cycle; starvation is impossible.
- Priority registers and `rpend`/`rsel` update on the rising edge, or asynchronously on the falling edge of RST_N.

## Configuration
- `RAM_ARB_WR_BYPASS_EN` defined: when a granted write and a granted read hit the same address in one cycle, the arbiter registers the bypass flag and WDAT. In cycle N+1 the read returns the new data instead of RAM_RDAT. This costs 1 flag flop and data_width data flops; both reset to 0.
- Not defined: the read returns RAM_RDAT unchanged (old data). No bypass logic is present.

## Structure
- Package `ram_arb_pkg`:
  - `NUM_REQ` = 2.
  - Typedef `req_id_t` (1 bit).
  - Localparams `RD` = 0, `WR` = 1 for WE decoding.
- Sub-module `rr_pick2`: 2-way round-robin picker with its priority flop. Inputs: clock, reset, req[1:0]. Outputs: gnt[1:0], win id. Instantiated once for the write port and once for the read port.

## Test plan
- Reset: hold RST_N low with REQ0 = REQ1 = 1 → GNT = 0, RVALID = 0, RAM_WEN = 0. Release → REQ0 is granted first on each port.
- Write-read: REQ0 writes 0xA5 to 0x10 in cycle 0, then reads 0x10 in cycle 1 → RVALID0 = 1 and RDAT0 = 0xA5 in cycle 2; RVALID1 stays 0.
- Contention: both requesters read continuously (addresses 0x01 and 0x02) → grants alternate 0, 1, 0, 1. Each RVALID arrives one cycle after its grant and carries its own data.
- Mixed: REQ0 writes 0x3C to 0x20 while REQ1 reads 0x20 in the same cycle → both granted. Next cycle RDAT1 = old value without the macro, 0x3C with `RAM_ARB_WR_BYPASS_EN`.
- Reset mid-read: grant a read, then assert RST_N before the next edge → no RVALID follows and priorities return to 0.
- Random soak: 10k cycles of random REQ/WE/ADR checked against a reference memory model → every read matches, and no requester waits more than 1 cycle.
